hilo_md_ctrl: RTL and testbench
===============================

# hilo_md_ctrl

Multiply/divide sequencer that owns every write into the HI/LO register pair. It sits beside the EX stage and accepts MULT, MULTU, DIV, DIVU, MTHI and MTLO operations. It runs multi-cycle arithmetic, stalls the pipeline while busy and drives the HI/LO write port (`we`, `hi_i`, `lo_i`) with a single-cycle write pulse. Pipeline flushes cancel in-flight work without a write.

## Interface
- `DATA_W`, default 32: operand and HI/LO width; equals `RegBus` width.
- `clk`  in  1  clock; reset `rst`, synchronous, active-high.
- `rst`  in  1  synchronous active-high reset.
- `start_i`  in  1  EX stage presents a valid HI/LO op this cycle.
- `op_i`  in  3  op code: MD_MULT, MD_MULTU, MD_DIV, MD_DIVU, MD_MTHI, MD_MTLO; any other value is ignored.
- `opa_i`, `opb_i`  in  DATA_W  rs, rt operands.
- `flush_i`  in  1  exception/flush; kills the current op.
- `hi_cur_i`, `lo_cur_i`  in  DATA_W  current HI/LO register outputs.
- `stall_o`  out  1  hold EX and earlier stages.
- `busy_o`  out  1  state is not IDLE.
- `we_o`  out  1  HI/LO write enable, one-cycle pulse.
- `hi_o`, `lo_o`  out  DATA_W  HI/LO write data.

## Operation
- States: IDLE, MUL, DIV, DONE.
- IDLE, `start_i` and MULT/MULTU:
  - Latch the operands and signedness; go to MUL.
  - MUL computes the 64-bit product (signed or unsigned) into a register; go to DONE.
- IDLE, `start_i` and DIV/DIVU with `opb_i != 0`:
  - Latch the operand magnitudes and sign bits; start `div_iter`; go to DIV.
  - DIV lasts exactly 32 cycles, one restoring step per cycle; then go to DONE.
- DONE applies the signs for signed division:
  - Quotient is negated if the operand signs differ.
  - Remainder takes the sign of the dividend.
  - LO = quotient, HI = remainder.
  - For MULT/MULTU, HI = product[63:32] and LO = product[31:0].
- Divide by zero (DIV or DIVU with `opb_i == 0`): skip DIV and go IDLE→DONE. Result is HI = `opa_i`, LO = 32'hFFFF_FFFF.
- MTHI/MTLO in IDLE: no state change and no stall.
  - Next cycle, `we_o` = 1.
  - MTHI: `hi_o` = `opa_i`, `lo_o` = `lo_cur_i` captured at issue.
  - MTLO: `lo_o` = `opa_i`, `hi_o` = `hi_cur_i` captured at issue.
- DONE: `we_o` = 1 with the result registered; `start_i` is ignored in DONE because it is the same instruction; go to IDLE.
- `stall_o` = (IDLE & `start_i` & op is mul/div) | MUL | DIV. It is low in DONE so the instruction retires.
- Flush:
  - `flush_i` forces the state to IDLE and clears pending `we_o` at the next edge.
  - `we_o` output = `we_q & ~flush_i`, so a flush in DONE, or in the MTHI/MTLO pulse cycle, suppresses the write.
- Reset: state IDLE, `we_o` = 0, `hi_o` = `lo_o` = 0, `stall_o` = 0, `busy_o` = 0; iteration counter = 0. Reset during MUL or DIV abandons the op and produces no write.

## Timing
- Cycle 0 is the issue cycle in IDLE.
- MULT/MULTU: MUL in cycle 1, DONE in cycle 2. HI/LO update at the end of cycle 2. `stall_o` is high in cycles 0–1.
- DIV/DIVU: DIV in cycles 1–32, DONE in cycle 33. `stall_o` is high in cycles 0–32.
- Divide by zero: DONE in cycle 1. `stall_o` is high in cycle 0 only.
- MTHI/MTLO: `we_o` is high in cycle 1. Back-to-back MTHI/MTLO each produce a pulse one cycle later.
- If an MT pulse coincides with MUL entry from a following MULT, both proceed; the MT write lands first.
- Forwarding of `hi_o`/`lo_o` while `we_o` = 1 is the EX forwarding logic's responsibility.

## Structure
- Op-code constants MD_MULT=3'd1, MD_MULTU=3'd2, MD_DIV=3'd3, MD_DIVU=3'd4, MD_MTHI=3'd5, MD_MTLO=3'd6 go in `defines.v`.
- State encodings also go in `defines.v`, using existing `RegBus`, `ZeroWord` and `WriteEnable`.
- Sub-module `div_iter`: unsigned 32-step restoring divider.
  - Ports: `clk`, `rst`, `start`, `kill`, dividend, divisor, `quotient`, `remainder`, `done`.
  - 6-bit step counter; `kill` is driven by `flush_i | rst`.

## Test plan
- MULT 0xFFFFFFFF × 0x00000002 → `stall_o` high 2 cycles; `we_o` in cycle 2; HI = 0xFFFFFFFF, LO = 0xFFFFFFFE.
- MULTU of the same operands → HI = 0x00000001, LO = 0xFFFFFFFE.
- DIV −7 / 2 → `stall_o` high 33 cycles; LO = 0xFFFFFFFD, HI = 0xFFFFFFFF.
- DIVU 100 / 7 → LO = 0x0000000E, HI = 0x00000002.
- DIVU 5 / 0 → `we_o` in cycle 1; HI = 0x00000005, LO = 0xFFFFFFFF.
- Flush at DIV cycle 10 → no `we_o`; IDLE next cycle.
  - Then MTHI 0x1234 with `lo_cur_i` = 0xABCD → `we_o` next cycle; HI = 0x1234, LO = 0xABCD.
  - Then `rst` during MUL → no write; all outputs 0.

Source files
------------

// File: rtl/hilo_md_ctrl_pkg.sv
// Shared definitions for the HI/LO multiply/divide sequencer: op codes,
// FSM state encoding and a small op-class helper.
package hilo_md_ctrl_pkg;

  localparam int REG_BUS = 32;

  localparam logic [2:0] MD_MULT  = 3'd1;
  localparam logic [2:0] MD_MULTU = 3'd2;
  localparam logic [2:0] MD_DIV   = 3'd3;
  localparam logic [2:0] MD_DIVU  = 3'd4;
  localparam logic [2:0] MD_MTHI  = 3'd5;
  localparam logic [2:0] MD_MTLO  = 3'd6;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } md_state_e;

  // Ops that occupy the sequencer and therefore stall the pipeline on issue.
  function automatic logic is_muldiv(input logic [2:0] op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/hilo_md_ctrl_if.sv
// EX-stage <-> HI/LO sequencer signal bundle. The master is the EX stage,
// the slave is the sequencer that owns the HI/LO write port.
interface hilo_md_ctrl_if
  import hilo_md_ctrl_pkg::*;
#(
  parameter int DATA_W = REG_BUS
) ();

  logic              start_i;
  logic [2:0]        op_i;
  logic [DATA_W-1:0] opa_i;
  logic [DATA_W-1:0] opb_i;
  logic              flush_i;
  logic [DATA_W-1:0] hi_cur_i;
  logic [DATA_W-1:0] lo_cur_i;
  logic              stall_o;
  logic              busy_o;
  logic              we_o;
  logic [DATA_W-1:0] hi_o;
  logic [DATA_W-1:0] lo_o;

  modport master (
    output start_i, op_i, opa_i, opb_i, flush_i, hi_cur_i, lo_cur_i,
    input  stall_o, busy_o, we_o, hi_o, lo_o
  );

  modport slave (
    input  start_i, op_i, opa_i, opb_i, flush_i, hi_cur_i, lo_cur_i,
    output stall_o, busy_o, we_o, hi_o, lo_o
  );

endinterface

// File: rtl/hilo_md_ctrl_div_iter.sv
// Unsigned restoring divider, one quotient bit per cycle for W cycles.
// quotient/remainder present the post-step values in the cycle done is high.
module div_iter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         kill,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic [W-1:0] quotient,
  output logic [W-1:0] remainder,
  output logic         done
);

  logic [W-1:0] rem_q, rem_d;
  logic [W-1:0] quo_q, quo_d;
  logic [W-1:0] dsr_q, dsr_d;
  logic [5:0]   cnt_q, cnt_d;
  logic         active_q, active_d;

  logic [W:0]   shifted;
  logic [W:0]   rem_sub;
  logic         fits;
  logic [W-1:0] rem_step;
  logic [W-1:0] quo_step;

  // Partial remainder is always below the divisor, so the shifted value
  // needs just one extra bit before the trial subtraction.
  always_comb begin
    shifted  = {rem_q, quo_q[W-1]};
    rem_sub  = shifted - {1'b0, dsr_q};
    fits     = shifted >= {1'b0, dsr_q};
    rem_step = W'(fits ? rem_sub : shifted);
    quo_step = {quo_q[W-2:0], fits};
  end

  assign done      = active_q && (cnt_q == 6'(W - 1));
  assign quotient  = quo_step;
  assign remainder = rem_step;

  always_comb begin
    rem_d    = rem_q;
    quo_d    = quo_q;
    dsr_d    = dsr_q;
    cnt_d    = cnt_q;
    active_d = active_q;
    if (start) begin
      rem_d    = '0;
      quo_d    = dividend;
      dsr_d    = divisor;
      cnt_d    = '0;
      active_d = 1'b1;
    end else if (active_q) begin
      rem_d = rem_step;
      quo_d = quo_step;
      cnt_d = cnt_q + 6'd1;
      if (done) active_d = 1'b0;
    end
    if (kill) begin
      cnt_d    = '0;
      active_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rem_q    <= '0;
      quo_q    <= '0;
      dsr_q    <= '0;
      cnt_q    <= '0;
      active_q <= 1'b0;
    end else begin
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dsr_q    <= dsr_d;
      cnt_q    <= cnt_d;
      active_q <= active_d;
    end
  end

endmodule

// File: rtl/hilo_md_ctrl.sv
// HI/LO multiply/divide sequencer: runs MULT/DIV ops, stalls EX while busy
// and issues every HI/LO write as a registered one-cycle pulse.
module hilo_md_ctrl
  import hilo_md_ctrl_pkg::*;
#(
  parameter int DATA_W = REG_BUS
) (
  input logic           clk,
  input logic           rst,
  hilo_md_ctrl_if.slave md
);

  md_state_e         state_q, state_d;
  logic [DATA_W-1:0] opa_q, opa_d;
  logic [DATA_W-1:0] opb_q, opb_d;
  logic [DATA_W-1:0] hi_q, hi_d;
  logic [DATA_W-1:0] lo_q, lo_d;
  logic              sgn_q, sgn_d;
  logic              q_neg_q, q_neg_d;
  logic              r_neg_q, r_neg_d;
  logic              we_q, we_d;

  logic                div_start;
  logic                div_done;
  logic                a_neg, b_neg;
  logic [DATA_W-1:0]   div_a, div_b;
  logic [DATA_W-1:0]   div_quo, div_rem;
  logic [2*DATA_W-1:0] ext_a, ext_b, product;
  logic                issue_md;

  assign issue_md = (state_q == ST_IDLE) && md.start_i && is_muldiv(md.op_i);

  // Signed division runs on magnitudes; the signs are reapplied on completion.
  assign a_neg = (md.op_i == MD_DIV) && md.opa_i[DATA_W-1];
  assign b_neg = (md.op_i == MD_DIV) && md.opb_i[DATA_W-1];
  assign div_a = a_neg ? -md.opa_i : md.opa_i;
  assign div_b = b_neg ? -md.opb_i : md.opb_i;

  assign ext_a   = {{DATA_W{sgn_q & opa_q[DATA_W-1]}}, opa_q};
  assign ext_b   = {{DATA_W{sgn_q & opb_q[DATA_W-1]}}, opb_q};
  assign product = ext_a * ext_b;

  div_iter #(.W(DATA_W)) u_div_iter (
    .clk       (clk),
    .rst       (rst),
    .start     (div_start),
    .kill      (md.flush_i | rst),
    .dividend  (div_a),
    .divisor   (div_b),
    .quotient  (div_quo),
    .remainder (div_rem),
    .done      (div_done)
  );

  always_comb begin
    state_d   = state_q;
    opa_d     = opa_q;
    opb_d     = opb_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    sgn_d     = sgn_q;
    q_neg_d   = q_neg_q;
    r_neg_d   = r_neg_q;
    we_d      = 1'b0;
    div_start = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (md.start_i) begin
          case (md.op_i)
            MD_MULT, MD_MULTU: begin
              opa_d   = md.opa_i;
              opb_d   = md.opb_i;
              sgn_d   = (md.op_i == MD_MULT);
              state_d = ST_MUL;
            end
            MD_DIV, MD_DIVU: begin
              if (md.opb_i == '0) begin
                hi_d    = md.opa_i;
                lo_d    = '1;
                we_d    = 1'b1;
                state_d = ST_DONE;
              end else begin
                div_start = 1'b1;
                q_neg_d   = a_neg ^ b_neg;
                r_neg_d   = a_neg;
                state_d   = ST_DIV;
              end
            end
            MD_MTHI: begin
              hi_d = md.opa_i;
              lo_d = md.lo_cur_i;
              we_d = 1'b1;
            end
            MD_MTLO: begin
              hi_d = md.hi_cur_i;
              lo_d = md.opa_i;
              we_d = 1'b1;
            end
            default: ;
          endcase
        end
      end
      ST_MUL: begin
        hi_d    = product[2*DATA_W-1:DATA_W];
        lo_d    = product[DATA_W-1:0];
        we_d    = 1'b1;
        state_d = ST_DONE;
      end
      ST_DIV: begin
        if (div_done) begin
          lo_d    = q_neg_q ? -div_quo : div_quo;
          hi_d    = r_neg_q ? -div_rem : div_rem;
          we_d    = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (md.flush_i) begin
      state_d   = ST_IDLE;
      hi_d      = hi_q;
      lo_d      = lo_q;
      we_d      = 1'b0;
      div_start = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      opa_q   <= '0;
      opb_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      sgn_q   <= 1'b0;
      q_neg_q <= 1'b0;
      r_neg_q <= 1'b0;
      we_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      sgn_q   <= sgn_d;
      q_neg_q <= q_neg_d;
      r_neg_q <= r_neg_d;
      we_q    <= we_d;
    end
  end

  // A flush arriving in the pulse cycle still suppresses the write.
  assign md.we_o    = we_q & ~md.flush_i;
  assign md.hi_o    = hi_q;
  assign md.lo_o    = lo_q;
  assign md.busy_o  = (state_q != ST_IDLE);
  assign md.stall_o = issue_md || (state_q == ST_MUL) || (state_q == ST_DIV);

endmodule

// File: tb/tb_hilo_md_ctrl.sv
// Scoreboard bench for hilo_md_ctrl: directed ops push expected HI/LO writes,
// a negedge monitor pops and compares every write pulse.
module tb_hilo_md_ctrl;
  import hilo_md_ctrl_pkg::*;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fails;
  logic [63:0] exp_q[$];

  hilo_md_ctrl_if m ();

  hilo_md_ctrl dut (
    .clk (clk),
    .rst (rst),
    .md  (m)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every write pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (m.we_o === 1'b1) begin
      if (exp_q.size() == 0) begin
        checkOutput("unexpected write", 64'd1, 64'd0);
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        checkOutput("write hi", {32'd0, m.hi_o}, {32'd0, e[63:32]});
        checkOutput("write lo", {32'd0, m.lo_o}, {32'd0, e[31:0]});
      end
    end
  end

  // Issues one op, counts stall cycles up to the write and notes its cycle.
  task automatic applyStimulus(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] hic, input logic [31:0] loc,
                               input int exp_stall, input int exp_we,
                               input logic [31:0] eh, input logic [31:0] el);
    int stall_cnt;
    int we_cyc;
    exp_q.push_back({eh, el});
    @(posedge clk); #1;
    m.start_i  = 1'b1;
    m.op_i     = op;
    m.opa_i    = a;
    m.opb_i    = b;
    m.hi_cur_i = hic;
    m.lo_cur_i = loc;
    stall_cnt  = 0;
    we_cyc     = -1;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (m.stall_o) stall_cnt++;
      if (m.we_o && we_cyc < 0) we_cyc = c;
      @(posedge clk); #1;
      m.start_i = 1'b0;
      if (we_cyc >= 0) break;
    end
    checkOutput("stall cycles", 64'(stall_cnt), 64'(exp_stall));
    checkOutput("write cycle", 64'(we_cyc), 64'(exp_we));
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    n_checks   = 0;
    n_fails    = 0;
    rst        = 1'b1;
    m.start_i  = 1'b0;
    m.op_i     = 3'd0;
    m.opa_i    = '0;
    m.opb_i    = '0;
    m.flush_i  = 1'b0;
    m.hi_cur_i = '0;
    m.lo_cur_i = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("reset we", 64'(m.we_o), 64'd0);
    checkOutput("reset stall", 64'(m.stall_o), 64'd0);
    checkOutput("reset busy", 64'(m.busy_o), 64'd0);
    checkOutput("reset hi", 64'(m.hi_o), 64'd0);
    checkOutput("reset lo", 64'(m.lo_o), 64'd0);

    applyStimulus(MD_MULT,  32'hFFFF_FFFF, 32'h0000_0002, 0, 0, 2, 2, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    applyStimulus(MD_MULTU, 32'hFFFF_FFFF, 32'h0000_0002, 0, 0, 2, 2, 32'h0000_0001, 32'hFFFF_FFFE);
    applyStimulus(MD_MULT,  32'h8000_0000, 32'h8000_0000, 0, 0, 2, 2, 32'h4000_0000, 32'h0000_0000);
    applyStimulus(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 2, 2, 32'hFFFF_FFFE, 32'h0000_0001);
    applyStimulus(MD_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 0, 0, 33, 33, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    applyStimulus(MD_DIV,   32'h0000_0007, 32'hFFFF_FFFE, 0, 0, 33, 33, 32'h0000_0001, 32'hFFFF_FFFD);
    applyStimulus(MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 33, 33, 32'h0000_0000, 32'h8000_0000);
    applyStimulus(MD_DIVU,  32'd100,       32'd7,         0, 0, 33, 33, 32'h0000_0002, 32'h0000_000E);
    applyStimulus(MD_DIVU,  32'd5,         32'd0,         0, 0, 1, 1, 32'h0000_0005, 32'hFFFF_FFFF);

    // Flush in DIV cycle 10: no write, idle next cycle.
    @(posedge clk); #1;
    m.start_i = 1'b1; m.op_i = MD_DIV; m.opa_i = 32'hFFFF_FFF9; m.opb_i = 32'd2;
    @(posedge clk); #1;
    m.start_i = 1'b0;
    repeat (9) @(posedge clk);
    #1 m.flush_i = 1'b1;
    @(posedge clk); #1;
    m.flush_i = 1'b0;
    @(negedge clk);
    checkOutput("busy after flush", 64'(m.busy_o), 64'd0);
    checkOutput("stall after flush", 64'(m.stall_o), 64'd0);
    repeat (40) @(posedge clk);

    applyStimulus(MD_MTHI, 32'h0000_1234, 32'd0, 32'h5555_5555, 32'h0000_ABCD, 0, 1, 32'h0000_1234, 32'h0000_ABCD);
    applyStimulus(MD_MTLO, 32'h00C0_FFEE, 32'd0, 32'h0000_7777, 32'h1111_1111, 0, 1, 32'h0000_7777, 32'h00C0_FFEE);

    // Flush during the DONE pulse of a divide-by-zero suppresses the write.
    @(posedge clk); #1;
    m.start_i = 1'b1; m.op_i = MD_DIVU; m.opa_i = 32'd9; m.opb_i = 32'd0;
    @(posedge clk); #1;
    m.start_i = 1'b0;
    m.flush_i = 1'b1;
    @(negedge clk);
    checkOutput("we under flush", 64'(m.we_o), 64'd0);
    @(posedge clk); #1;
    m.flush_i = 1'b0;
    @(negedge clk);
    checkOutput("busy after done flush", 64'(m.busy_o), 64'd0);

    // Reset in MUL abandons the op and clears all outputs.
    @(posedge clk); #1;
    m.start_i = 1'b1; m.op_i = MD_MULT; m.opa_i = 32'd3; m.opb_i = 32'd4;
    @(posedge clk); #1;
    m.start_i = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("rst-in-mul we", 64'(m.we_o), 64'd0);
    checkOutput("rst-in-mul stall", 64'(m.stall_o), 64'd0);
    checkOutput("rst-in-mul busy", 64'(m.busy_o), 64'd0);
    checkOutput("rst-in-mul hi", 64'(m.hi_o), 64'd0);
    checkOutput("rst-in-mul lo", 64'(m.lo_o), 64'd0);
    repeat (5) @(posedge clk);

    checkOutput("pending writes", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
